pulse_cmd_sequencer: RTL and testbench

Synchronous UART command-frame parser and burst sequencer for the dual-channel pulse generator. It collects 8-byte frames from `uart_rx` using its `po_data`/`po_flag` interface and validates opcode and checksum. It then drives `pulse_out1`/`pulse_out2` with programmed widths, inter-pulse gap and repeat count, and returns a one-byte acknowledge to `uart_tx`. It replaces ad-hoc frame capture clocked on `po_flag`; every register sits on `sys_clk`.

---
 rtl/pulse_cmd_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_pulse_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_sequencer.sv
// UART command-frame parser and dual-channel pulse burst sequencer.
// In: sys_clk, sys_rst, po_data/po_flag. Out: pulse_out1/2, busy, tx_data/tx_flag.
module pulse_cmd_sequencer #(
  parameter int TIMEOUT_CYC = 200_000,
  parameter int PAIR_SPACE  = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] po_data,
  input  logic       po_flag,
  output logic       pulse_out1,
  output logic       pulse_out2,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_flag
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, P1, GAP, P2, SPACE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      rem_q, rem_d;
  logic [2:0]      byte_q, byte_d;
  logic [TW-1:0]   to_q, to_d;
  logic [7:0]      frm_q [8];
  logic [7:0]      frm_d [8];
  logic [7:0]      csum_q, csum_d;
  logic            act1_q, act1_d;
  logic            act2_q, act2_d;
  logic [7:0]      w1_q, w1_d;
  logic [7:0]      w2_q, w2_d;
  logic [7:0]      g_q, g_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_flag_q, tx_flag_d;
  logic            p1_q, p1_d;
  logic            p2_q, p2_d;
  logic            busy_q, busy_d;

  logic            frame_done;
  logic            pair_end;
  logic            pair_start;
  logic            new_a1;
  logic            new_a2;
  logic [7:0]      op;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    byte_d     = byte_q;
    to_d       = to_q;
    frm_d      = frm_q;
    csum_d     = csum_q;
    act1_d     = act1_q;
    act2_d     = act2_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    g_d        = g_q;
    tx_data_d  = tx_data_q;
    tx_flag_d  = 1'b0;
    frame_done = 1'b0;
    pair_end   = 1'b0;
    pair_start = 1'b0;
    op         = frm_q[0];
    new_a1     = (frm_q[1] != 8'd0) && (frm_q[3] != 8'd0);
    new_a2     = (frm_q[2] != 8'd0) && (frm_q[4] != 8'd0);

    // Byte collection; a strobe always wins over a timeout expiry.
    if (po_flag) begin
      byte_d         = byte_q + 3'd1;
      to_d           = '0;
      frm_d[byte_q]  = po_data;
      csum_d         = (byte_q == 3'd0) ? po_data : (csum_q ^ po_data);
      frame_done     = (byte_q == 3'd7);
    end else if (byte_q != 3'd0) begin
      if (to_q == TW'(TIMEOUT_CYC)) begin
        byte_d = '0;
        to_d   = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end

    unique case (state_q)
      IDLE: state_d = IDLE;
      P1: begin
        if (cnt_q == 16'd0) begin
          if (!act2_q) begin
            pair_end = 1'b1;
          end else if (g_q != 8'd0) begin
            state_d = GAP;
            cnt_d   = {8'd0, g_q} - 16'd1;
          end else begin
            state_d = P2;
            cnt_d   = {8'd0, w2_q} - 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = P2;
          cnt_d   = {8'd0, w2_q} - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      P2: begin
        if (cnt_q == 16'd0) pair_end = 1'b1;
        else cnt_d = cnt_q - 16'd1;
      end
      SPACE: begin
        if (cnt_q == 16'd0) pair_start = 1'b1;
        else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (pair_end) begin
      rem_d = rem_q - 8'd1;
      if (rem_q == 8'd1) begin
        state_d = IDLE;
      end else begin
        state_d = SPACE;
        cnt_d   = 16'(PAIR_SPACE - 1);
      end
    end

    if (pair_start) begin
      if (act1_q) begin
        state_d = P1;
        cnt_d   = {8'd0, w1_q} - 16'd1;
      end else begin
        state_d = P2;
        cnt_d   = {8'd0, w2_q} - 16'd1;
      end
    end

    // Completed frame overrides the burst sequencing above.
    if (frame_done) begin
      tx_flag_d = 1'b1;
      if (csum_q != po_data) begin
        tx_data_d = 8'hE1;
      end else if (op != 8'h00 && op != 8'h07) begin
        tx_data_d = 8'hE2;
      end else if (op == 8'h07 && state_q != IDLE) begin
        tx_data_d = 8'hE3;
      end else if (op == 8'h00) begin
        tx_data_d = 8'hA5;
        state_d   = IDLE;
        cnt_d     = '0;
      end else begin
        tx_data_d = 8'hA5;
        act1_d    = new_a1;
        act2_d    = new_a2;
        w1_d      = frm_q[3];
        w2_d      = frm_q[4];
        g_d       = frm_q[5];
        rem_d     = (frm_q[6] == 8'd0) ? 8'd1 : frm_q[6];
        if (new_a1) begin
          state_d = P1;
          cnt_d   = {8'd0, frm_q[3]} - 16'd1;
        end else if (new_a2) begin
          state_d = P2;
          cnt_d   = {8'd0, frm_q[4]} - 16'd1;
        end else begin
          state_d = IDLE;
        end
      end
    end

    p1_d   = (state_d == P1);
    p2_d   = (state_d == P2);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      byte_q    <= '0;
      to_q      <= '0;
      frm_q     <= '{default: '0};
      csum_q    <= '0;
      act1_q    <= 1'b0;
      act2_q    <= 1'b0;
      w1_q      <= '0;
      w2_q      <= '0;
      g_q       <= '0;
      tx_data_q <= '0;
      tx_flag_q <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      byte_q    <= byte_d;
      to_q      <= to_d;
      frm_q     <= frm_d;
      csum_q    <= csum_d;
      act1_q    <= act1_d;
      act2_q    <= act2_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      g_q       <= g_d;
      tx_data_q <= tx_data_d;
      tx_flag_q <= tx_flag_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      busy_q    <= busy_d;
    end
  end

  assign pulse_out1 = p1_q;
  assign pulse_out2 = p2_q;
  assign busy       = busy_q;
  assign tx_data    = tx_data_q;
  assign tx_flag    = tx_flag_q;

endmodule

// File: tb/tb_pulse_cmd_sequencer.sv
// Scoreboard bench for pulse_cmd_sequencer.
// Acks checked from a queue; pulse traces checked against a burst model.
module tb_pulse_cmd_sequencer;

  localparam int TO    = 200;
  localparam int SPACE = 1000;

  logic       clk;
  logic       rst;
  logic [7:0] po_data;
  logic       po_flag;
  logic       p1;
  logic       p2;
  logic       busy;
  logic [7:0] tx_data;
  logic       tx_flag;

  int n_tests;
  int n_fail;
  logic [7:0] ack_q[$];

  pulse_cmd_sequencer #(
    .TIMEOUT_CYC(TO),
    .PAIR_SPACE (SPACE)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .pulse_out1(p1),
    .pulse_out2(p2),
    .busy      (busy),
    .tx_data   (tx_data),
    .tx_flag   (tx_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(
    input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    return {b0, b1, b2, b3, b4, b5, b6,
            b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6};
  endfunction

  // Drives bytes lo..hi of a frame, one per cycle, from a negedge.
  task automatic send_bytes(input logic [63:0] fr,
                            input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      po_data = fr[63 - 8*i -: 8];
      po_flag = 1'b1;
      @(negedge clk);
    end
    po_flag = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] fr,
                            input logic [7:0] ack);
    ack_q.push_back(ack);
    send_bytes(fr, 0, 7);
  endtask

  // Compares {p1,p2,busy} per cycle against a burst model.
  task automatic trace(input string tag, input logic [63:0] fr);
    logic [7:0] w1, w2, g, rr;
    bit a1, a2;
    int r, bad, nb, eb;
    logic [2:0] exp[$];
    logic [2:0] got;
    w1 = fr[39:32];
    w2 = fr[31:24];
    g  = fr[23:16];
    rr = fr[15:8];
    a1 = (fr[55:48] != 0) && (w1 != 0);
    a2 = (fr[47:40] != 0) && (w2 != 0);
    r  = (rr == 0) ? 1 : int'(rr);
    for (int p = 0; p < r; p++) begin
      if (a1) repeat (w1) exp.push_back(3'b101);
      if (a1 && a2) repeat (g) exp.push_back(3'b001);
      if (a2) repeat (w2) exp.push_back(3'b011);
      if (p != r - 1 && (a1 || a2))
        repeat (SPACE) exp.push_back(3'b001);
    end
    repeat (5) exp.push_back(3'b000);
    bad = -1;
    nb  = 0;
    eb  = 0;
    foreach (exp[i]) begin
      got = {p1, p2, busy};
      if (got !== exp[i] && bad < 0) bad = i;
      nb += int'(busy);
      eb += int'(exp[i][0]);
      @(negedge clk);
    end
    chk({tag, "_first_bad_cycle"}, bad, -1);
    chk({tag, "_busy_len"}, nb, eb);
  endtask

  task automatic idle_check(input string tag, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      if (p1 || p2 || busy) hits++;
      @(negedge clk);
    end
    chk({tag, "_active_cycles"}, hits, 0);
  endtask

  always @(negedge clk) begin
    if (tx_flag) begin
      if (ack_q.size() == 0) chk("ack_spurious", {24'd0, tx_data}, 32'hFFFF);
      else chk("ack", {24'd0, tx_data}, {24'd0, ack_q.pop_front()});
    end
  end

  initial begin
    logic [63:0] fa, fb, fx;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    po_flag = 1'b0;
    po_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_p1", p1, 0);
    chk("rst_p2", p2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_txf", tx_flag, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic two-pair burst.
    fa = mk(8'h07, 8'h01, 8'h01, 8'h04, 8'h03, 8'h02, 8'h02);
    chk("fa_checksum", fa[7:0], 8'h00);
    send_frame(fa, 8'hA5);
    trace("fire", fa);

    // Bad checksum, bad opcode, both channels inactive.
    fx = {fa[63:8], 8'h55};
    send_frame(fx, 8'hE1);
    idle_check("badcs", 20);
    fx = 64'h0900000000000009;
    send_frame(fx, 8'hE2);
    idle_check("badop", 20);
    fx = mk(8'h07, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h02);
    send_frame(fx, 8'hA5);
    idle_check("noch", 20);

    // Partial frame discarded by timeout; W1=255, G=0 burst after.
    send_bytes(fa, 0, 2);
    repeat (TO + 50) @(negedge clk);
    fx = mk(8'h07, 8'h01, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h01);
    send_frame(fx, 8'hA5);
    trace("timeout", fx);

    // Gap well below the timeout keeps the frame alive.
    fx = mk(8'h07, 8'h01, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01);
    ack_q.push_back(8'hA5);
    send_bytes(fx, 0, 2);
    repeat (TO - 50) @(negedge clk);
    send_bytes(fx, 3, 7);
    trace("slow", fx);

    // Stop during the second of ten pairs.
    fx = mk(8'h07, 8'h01, 8'h01, 8'h04, 8'h03, 8'h02, 8'h0A);
    send_frame(fx, 8'hA5);
    repeat (1007) @(negedge clk);
    chk("prestop_busy", busy, 1);
    send_frame(64'h0, 8'hA5);
    chk("stop_p1", p1, 0);
    chk("stop_p2", p2, 0);
    chk("stop_busy", busy, 0);
    idle_check("stopped", 30);

    // Fire while busy is rejected; running burst unchanged.
    fb = mk(8'h07, 8'h01, 8'h01, 8'h09, 8'h09, 8'h09, 8'h05);
    send_frame(fa, 8'hA5);
    fork
      trace("busyfire", fa);
      begin
        repeat (20) @(negedge clk);
        send_frame(fb, 8'hE3);
      end
    join

    // Channel 1 only.
    fx = mk(8'h07, 8'h01, 8'h00, 8'h05, 8'h09, 8'h03, 8'h01);
    send_frame(fx, 8'hA5);
    trace("ch1only", fx);

    // Reset mid-P1 with a partial frame pending.
    fx = mk(8'h07, 8'h01, 8'h01, 8'h32, 8'h03, 8'h02, 8'h01);
    send_frame(fx, 8'hA5);
    send_bytes(fa, 0, 2);
    chk("prerst_p1", p1, 1);
    rst = 1'b1;
    #1;
    chk("mrst_p1", p1, 0);
    chk("mrst_p2", p2, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_txd", tx_data, 0);
    chk("mrst_txf", tx_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fx = mk(8'h07, 8'h01, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01);
    send_frame(fx, 8'hA5);
    trace("postrst", fx);

    repeat (5) @(negedge clk);
    chk("ack_pending", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
